boot_loader: RTL and testbench

Upstream stage of the multicycle 64-bit CPU. It holds the CPU in reset after power-up and receives a program image as a byte stream from the host-side UART receiver. It writes the image word-by-word into instruction memory, checks it, and then releases the CPU to fetch from address 0. A reload request returns the CPU to reset and restarts the load.

---
 rtl/boot_loader.sv | 215 +++++++++++++++++++++
 tb/tb_boot_loader.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - program image loader that holds the CPU in reset until a framed image is written to instruction memory
//
// Receives a byte stream: 16-bit little-endian word count N, N little-endian
// 32-bit words, and (with BOOT_CHECKSUM_EN defined) one trailing XOR checksum
// byte. Each completed word is written to instruction memory at word_index*4.
// The CPU is released once the whole image has been accepted (and the checksum
// matches, when enabled). A reload request restarts the load from the header.
//
// Optional feature macro: BOOT_CHECKSUM_EN (undefined by default: no checksum
// byte, image is accepted as soon as word N arrives).
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   s_valid    in   host byte valid
//   s_data     in   host byte [7:0]
//   s_ready    out  loader accepts a byte (beat = s_valid && s_ready)
//   reload     in   one-cycle request to restart the load
//   mem_we     out  instruction memory write strobe, one cycle per word
//   mem_addr   out  word-aligned byte address [ADDR_W-1:0]
//   mem_wdata  out  word to write [31:0]
//   cpu_reset  out  active-high CPU reset, 1 until a valid image is loaded
//   done       out  image loaded, CPU running
//   err        out  load failed, sticky until reload or reset

module boot_loader #(
   parameter int MAX_WORDS = 256,
   parameter int ADDR_W    = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   input  logic              reload,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              err
);

   localparam int          WC_W  = ADDR_W - 2;
   localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

`ifdef BOOT_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE, S_HDR_LO, S_HDR_HI, S_DATA, S_CHK, S_RUN, S_ERR
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_HDR_LO, S_HDR_HI, S_DATA, S_RUN, S_ERR
   } state_t;
`endif

   state_t            state_q;
   logic [15:0]       n_q;
   logic [1:0]        byte_q;
   logic [23:0]       shift_q;
   logic [WC_W-1:0]   word_q;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]        xor_q;
`endif
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q;
   logic              cpu_reset_q;
   logic              done_q;
   logic              err_q;

   logic              beat;
   logic [15:0]       hdr_n;
   logic [16:0]       words_written;
   logic              last_word;

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_reset = cpu_reset_q;
   assign done      = done_q;
   assign err       = err_q;

   // s_ready decodes the state; a reload in the same cycle blocks the beat.
   always_comb begin
      s_ready = 1'b0;
      case (state_q)
         S_HDR_LO, S_HDR_HI, S_DATA: s_ready = 1'b1;
`ifdef BOOT_CHECKSUM_EN
         S_CHK:                      s_ready = 1'b1;
`endif
         default:                    s_ready = 1'b0;
      endcase
      if (reload) begin
         s_ready = 1'b0;
      end
   end

   assign beat  = s_valid & s_ready;
   assign hdr_n = {s_data, n_q[7:0]};

   // Widened so that the compare with N == MAX_WORDS cannot overflow the
   // word counter.
   assign words_written = 17'(word_q) + 17'd1;
   assign last_word     = (words_written == {1'b0, n_q});

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         n_q         <= '0;
         byte_q      <= '0;
         shift_q     <= '0;
         word_q      <= '0;
`ifdef BOOT_CHECKSUM_EN
         xor_q       <= '0;
`endif
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         if (reload) begin
            // Clearing byte_q discards any partial word; shift_q is fully
            // overwritten before it is used again.
            state_q     <= S_HDR_LO;
            byte_q      <= '0;
            word_q      <= '0;
`ifdef BOOT_CHECKSUM_EN
            xor_q       <= '0;
`endif
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  state_q <= S_HDR_LO;
               end
               S_HDR_LO: begin
                  if (beat) begin
                     n_q[7:0] <= s_data;
                     state_q  <= S_HDR_HI;
                  end
               end
               S_HDR_HI: begin
                  if (beat) begin
                     n_q <= hdr_n;
                     if (hdr_n > MAX_N) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                     end else if (hdr_n == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
                        state_q     <= S_CHK;
`else
                        state_q     <= S_RUN;
                        done_q      <= 1'b1;
                        cpu_reset_q <= 1'b0;
`endif
                     end else begin
                        state_q <= S_DATA;
                     end
                  end
               end
               S_DATA: begin
                  if (beat) begin
`ifdef BOOT_CHECKSUM_EN
                     xor_q   <= xor_q ^ s_data;
`endif
                     byte_q  <= byte_q + 2'd1;
                     // Bytes enter at the top so byte 0 ends up in bits [7:0].
                     shift_q <= {s_data, shift_q[23:8]};
                     if (byte_q == 2'd3) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {word_q, 2'b00};
                        mem_wdata_q <= {s_data, shift_q};
                        if (last_word) begin
`ifdef BOOT_CHECKSUM_EN
                           state_q     <= S_CHK;
`else
                           state_q     <= S_RUN;
                           done_q      <= 1'b1;
                           cpu_reset_q <= 1'b0;
`endif
                        end else begin
                           word_q <= word_q + 1'b1;
                        end
                     end
                  end
               end
`ifdef BOOT_CHECKSUM_EN
               S_CHK: begin
                  if (beat) begin
                     if (s_data == xor_q) begin
                        state_q     <= S_RUN;
                        done_q      <= 1'b1;
                        cpu_reset_q <= 1'b0;
                     end else begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                     end
                  end
               end
`endif
               default: begin
                  state_q <= state_q;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - self-checking bench for boot_loader with a byte-queue reference model
module tb_boot_loader;
   localparam int MAX_WORDS = 256;
   localparam int ADDR_W    = 10;
`ifdef BOOT_CHECKSUM_EN
   localparam int CHK = 1;
`else
   localparam int CHK = 0;
`endif

   logic              clock;
   logic              reset;
   logic              s_valid;
   logic [7:0]        s_data;
   logic              s_ready;
   logic              reload;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_reset;
   logic              done;
   logic              err;

   int checks   = 0;
   int failures = 0;

   boot_loader #(.MAX_WORDS(MAX_WORDS), .ADDR_W(ADDR_W)) dut (
      .clock(clock), .reset(reset), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .done(done), .err(err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: bytes accepted since the last reload, interpreted as a frame.
   logic [7:0]        bq[$];
   bit                m_idle, m_done, m_err;
   logic              exp_we, exp_cpu_reset;
   logic [ADDR_W-1:0] exp_addr;
   logic [31:0]       exp_wdata;

   task automatic model_byte();
      int n, nw, k;
      logic [7:0] x;
      n = bq.size();
      if (n < 2) return;
      nw = int'(bq[1]) * 256 + int'(bq[0]);
      if (n == 2 && nw > MAX_WORDS) begin
         m_err = 1;
         return;
      end
      k = n - 2;
      if (k > 0 && k <= 4 * nw && (k % 4) == 0) begin
         exp_we    = 1'b1;
         exp_addr  = ADDR_W'((k / 4 - 1) * 4);
         exp_wdata = {bq[n-1], bq[n-2], bq[n-3], bq[n-4]};
      end
      if (n == 2 + 4 * nw + CHK) begin
         if (CHK == 1) begin
            x = 8'h00;
            for (int i = 2; i < n - 1; i++) x ^= bq[i];
            if (x == bq[n-1]) m_done = 1; else m_err = 1;
         end else begin
            m_done = 1;
         end
         exp_cpu_reset = !m_done;
      end
   endtask

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         bq.delete();
         m_idle = 1; m_done = 0; m_err = 0;
         exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_cpu_reset = 1'b1;
      end else begin
         exp_we = 1'b0;
         if (reload) begin
            bq.delete();
            m_idle = 0; m_done = 0; m_err = 0;
            exp_cpu_reset = 1'b1;
         end else if (m_idle) begin
            m_idle = 0;
         end else if (s_valid && !m_done && !m_err) begin
            bq.push_back(s_data);
            model_byte();
         end
      end
   end

   // Per-cycle comparison against the model, mid-cycle.
   always @(negedge clock) begin
      logic exp_rdy;
      exp_rdy = reset && !m_idle && !m_done && !m_err && !reload;
      check_eq("s_ready",   s_ready,   exp_rdy);
      check_eq("mem_we",    mem_we,    exp_we);
      check_eq("mem_addr",  mem_addr,  exp_addr);
      check_eq("mem_wdata", mem_wdata, exp_wdata);
      check_eq("cpu_reset", cpu_reset, exp_cpu_reset);
      check_eq("done",      done,      m_done);
      check_eq("err",       err,       m_err);
   end

   logic [41:0] wlog[$];
   always @(negedge clock) if (mem_we === 1'b1) wlog.push_back({mem_addr, mem_wdata});

   logic [7:0]  frame[$];
   logic [31:0] wq[$];

   task automatic make_frame(input int n, input bit bad);
      logic [7:0]  x;
      logic [31:0] w;
      x = 8'h00;
      frame.delete();
      frame.push_back(n[7:0]);
      frame.push_back(n[15:8]);
      if (n <= MAX_WORDS) begin
         foreach (wq[i]) begin
            w = wq[i];
            for (int b = 0; b < 4; b++) begin
               frame.push_back(w[8*b +: 8]);
               x ^= w[8*b +: 8];
            end
         end
         if (CHK == 1) frame.push_back(bad ? ~x : x);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the beat plus gap cycles.
   task automatic send_byte(input logic [7:0] b, input int gap, input bit must);
      bit ok;
      int lim;
      ok = 0;
      lim = must ? 50 : 3;
      s_valid = 1'b1;
      s_data  = b;
      for (int i = 0; i < lim; i++) begin
         @(negedge clock);
         if (s_ready) begin
            @(posedge clock); #1;
            ok = 1;
            break;
         end
      end
      s_valid = 1'b0;
      if (!ok) begin
         @(posedge clock); #1;
      end
      if (must) begin
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL beat_timeout: byte %0h not accepted within %0d cycles", b, lim);
         end
      end
      repeat (gap) begin @(posedge clock); #1; end
   endtask

   task automatic send_frame(input int gap, input int count);
      for (int i = 0; i < count && i < frame.size(); i++)
         send_byte(frame[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap, 1);
   endtask

   task automatic do_reload(input bit with_valid);
      s_valid = with_valid;
      s_data  = 8'hA5;
      reload  = 1'b1;
      @(posedge clock); #1;
      reload  = 1'b0;
      s_valid = 1'b0;
   endtask

   task automatic settle();
      repeat (2) begin @(posedge clock); #1; end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit bad;
      reset = 1'b0; s_valid = 1'b0; s_data = 8'h00; reload = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_eq("rst_s_ready", s_ready, 1'b0);
      check_eq("rst_cpu_reset", cpu_reset, 1'b1);
      check_eq("rst_mem_we", mem_we, 1'b0);
      reset = 1'b1;
      check_eq("idle_s_ready", s_ready, 1'b0);
      @(posedge clock); #1;
      check_eq("first_s_ready", s_ready, 1'b1);

      // Two-word frame, back to back.
      frame = {8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
      if (CHK == 1) frame.push_back(8'h71);
      wlog.delete();
      send_frame(0, frame.size());
      check_eq("t1_done_timing", done, 1'b1);
      settle();
      check_eq("t1_nwrites", wlog.size(), 2);
      check_eq("t1_w0", wlog[0], {10'd0, 32'h00500093});
      check_eq("t1_w1", wlog[1], {10'd4, 32'h00A00113});
      check_eq("t1_cpu_reset", cpu_reset, 1'b0);
      check_eq("t1_s_ready", s_ready, 1'b0);

`ifdef BOOT_CHECKSUM_EN
      // Bad checksum, then reload and the good frame.
      do_reload(0);
      frame[frame.size()-1] = 8'h72;
      send_frame(0, frame.size());
      check_eq("t2_err", err, 1'b1);
      check_eq("t2_cpu_reset", cpu_reset, 1'b1);
      settle();
      check_eq("t2_s_ready", s_ready, 1'b0);
      do_reload(0);
      frame[frame.size()-1] = 8'h71;
      send_frame(0, frame.size());
      check_eq("t2_done", done, 1'b1);
`endif

      // Empty image.
      do_reload(0);
      wq.delete(); make_frame(0, 0);
      wlog.delete();
      send_frame(0, frame.size());
      check_eq("t3_done", done, 1'b1);
      settle();
      check_eq("t3_nwrites", wlog.size(), 0);

      // Oversize count 257.
      do_reload(0);
      frame = {8'h01, 8'h01};
      wlog.delete();
      send_frame(0, 2);
      check_eq("t4_err", err, 1'b1);
      settle();
      check_eq("t4_nwrites", wlog.size(), 0);

      // Reload after 5 data bytes (beat offered alongside reload), then 1-word frame.
      do_reload(0);
      frame = {8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      send_frame(0, frame.size());
      do_reload(1);
      wlog.delete();
      frame = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
      if (CHK == 1) frame.push_back(8'h08);
      send_frame(0, frame.size());
      settle();
      check_eq("t5_nwrites", wlog.size(), 1);
      check_eq("t5_w0", wlog[0], {10'd0, 32'h12345678});
      check_eq("t5_done", done, 1'b1);

      // Two-word frame with 3 idle cycles between bytes.
      do_reload(0);
      wq = {32'h00500093, 32'h00A00113}; make_frame(2, 0);
      wlog.delete();
      send_frame(3, frame.size());
      check_eq("t6_nwrites", wlog.size(), 2);
      check_eq("t6_w0", wlog[0], {10'd0, 32'h00500093});
      check_eq("t6_w1", wlog[1], {10'd4, 32'h00A00113});
      check_eq("t6_done", done, 1'b1);

      // Full-capacity image.
      do_reload(0);
      wq.delete();
      for (int i = 0; i < MAX_WORDS; i++) wq.push_back($urandom);
      make_frame(MAX_WORDS, 0);
      send_frame(0, frame.size());
      settle();
      check_eq("t7_done", done, 1'b1);

      // Asynchronous reset in the middle of a frame.
      do_reload(0);
      wq = {32'hDEADBEEF}; make_frame(1, 0);
      send_frame(0, 3);
      reset = 1'b0;
      repeat (2) begin @(posedge clock); #1; end
      reset = 1'b1;
      @(posedge clock); #1;
      send_frame(0, frame.size());
      settle();
      check_eq("t8_done", done, 1'b1);

      // Randomized frames, gaps, corruptions, mid-frame reloads and stray bytes.
      for (int it = 0; it < 40; it++) begin
         do_reload($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) n = int'($urandom_range(MAX_WORDS + 1, 65535));
         else n = int'($urandom_range(0, 5));
         bad = ($urandom_range(0, 4) == 0);
         wq.delete();
         for (int i = 0; i < n && i <= MAX_WORDS; i++) wq.push_back($urandom);
         make_frame(n, bad);
         if ($urandom_range(0, 4) == 0) begin
            send_frame(-1, int'($urandom_range(0, frame.size() - 1)));
            do_reload($urandom_range(0, 1));
            make_frame(n, bad);
         end
         send_frame(-1, frame.size());
         send_byte(8'($urandom), 0, 0);
         settle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
